// File: rtl/cluster_pm_pkg.sv
// Shared definitions for the cluster power-management blocks: FSM state
// encoding, per-state output decode and default timing constants.
package cluster_pm_pkg;

  typedef enum logic [1:0] {
    ACTIVE = 2'd0,
    DRAIN  = 2'd1,
    GATED  = 2'd2,
    WAKE   = 2'd3
  } pm_state_e;

  typedef struct packed {
    logic en;
    logic ack;
    logic ready;
  } pm_out_t;

  localparam int unsigned DEF_IDLE_CYCLES = 8;
  localparam int unsigned DEF_WAKE_CYCLES = 2;
  localparam int unsigned DEF_CNT_WIDTH   = 16;

  // Bits needed for a counter that runs 0 .. n-1 (at least one bit).
  function automatic int unsigned cnt_bits(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  function automatic pm_out_t pm_decode(input pm_state_e s);
    pm_out_t o;
    o = '{en: 1'b1, ack: 1'b0, ready: 1'b1};
    case (s)
      GATED:   o = '{en: 1'b0, ack: 1'b1, ready: 1'b0};
      WAKE:    o = '{en: 1'b1, ack: 1'b0, ready: 1'b0};
      default: o = '{en: 1'b1, ack: 1'b0, ready: 1'b1};
    endcase
    return o;
  endfunction

endpackage

// File: rtl/cluster_sat_counter.sv
// Saturating up-counter with synchronous clear; clear beats increment.
module cluster_sat_counter #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/cluster_clock_gate_ctrl.sv
// Enable-side controller for the cluster clock gate: sleep handshake,
// idle-drain delay, wake settle delay and gated-cycle accounting.
module cluster_clock_gate_ctrl
  import cluster_pm_pkg::*;
#(
  parameter int unsigned IDLE_CYCLES = DEF_IDLE_CYCLES,
  parameter int unsigned WAKE_CYCLES = DEF_WAKE_CYCLES,
  parameter int unsigned CNT_WIDTH   = DEF_CNT_WIDTH
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 sleep_req_i,
  input  logic                 busy_i,
  input  logic                 wake_req_i,
  input  logic                 test_mode_i,
  input  logic                 cnt_clr_i,
  output logic                 en_o,
  output logic                 sleep_ack_o,
  output logic                 clk_ready_o,
  output logic [CNT_WIDTH-1:0] gated_cnt_o
);

  localparam int unsigned IDLE_W = cnt_bits(IDLE_CYCLES);
  localparam int unsigned WAKE_W = cnt_bits(WAKE_CYCLES);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'((IDLE_CYCLES == 0) ? 0 : IDLE_CYCLES - 1);
  localparam logic [WAKE_W-1:0] WAKE_LAST = WAKE_W'((WAKE_CYCLES == 0) ? 0 : WAKE_CYCLES - 1);

  pm_state_e          state;
  pm_out_t            out_q;
  logic [IDLE_W-1:0]  idle_cnt;
  logic [WAKE_W-1:0]  wake_cnt;
  logic               q;
  logic               w;

  // Wake has priority over sleep: any wake source disqualifies idling.
  assign q = sleep_req_i & ~busy_i & ~wake_req_i & ~test_mode_i;
  assign w = wake_req_i | busy_i | ~sleep_req_i | test_mode_i;

  // Outputs are loaded with the decode of the state being entered, so they
  // change on the same edge as the state and stay glitch-free.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      // NOTE: state registers use non-blocking assignments so every flop
      // samples pre-edge values regardless of statement order.
      state    <= ACTIVE;
      out_q    <= pm_decode(ACTIVE);
      idle_cnt <= '0;
      wake_cnt <= '0;
    end else begin
      case (state)
        ACTIVE: begin
          if (q) begin
            if (IDLE_CYCLES <= 1) begin
              state <= GATED;
              out_q <= pm_decode(GATED);
            end else begin
              state    <= DRAIN;
              out_q    <= pm_decode(DRAIN);
              idle_cnt <= IDLE_W'(1);
            end
          end else begin
            idle_cnt <= '0;
          end
        end
        DRAIN: begin
          if (!q) begin
            state    <= ACTIVE;
            out_q    <= pm_decode(ACTIVE);
            idle_cnt <= '0;
          end else if (idle_cnt == IDLE_LAST) begin
            state    <= GATED;
            out_q    <= pm_decode(GATED);
            idle_cnt <= '0;
          end else begin
            idle_cnt <= idle_cnt + 1'b1;
          end
        end
        GATED: begin
          if (w) begin
            wake_cnt <= '0;
            if (WAKE_CYCLES == 0) begin
              state <= ACTIVE;
              out_q <= pm_decode(ACTIVE);
            end else begin
              state <= WAKE;
              out_q <= pm_decode(WAKE);
            end
          end
        end
        WAKE: begin
          // The cluster clock is already running; finish settling before
          // reporting ready, whatever sleep_req_i does meanwhile.
          if (wake_cnt == WAKE_LAST) begin
            state    <= ACTIVE;
            out_q    <= pm_decode(ACTIVE);
            wake_cnt <= '0;
          end else begin
            wake_cnt <= wake_cnt + 1'b1;
          end
        end
        default: begin
          state <= ACTIVE;
          out_q <= pm_decode(ACTIVE);
        end
      endcase
    end
  end

  assign en_o        = out_q.en;
  assign sleep_ack_o = out_q.ack;
  assign clk_ready_o = out_q.ready;

  cluster_sat_counter #(
    .WIDTH (CNT_WIDTH)
  ) u_gated_cnt (
    .clk   (clk_i),
    .rst   (rst_i),
    .inc   (state == GATED),
    .clr   (cnt_clr_i),
    .count (gated_cnt_o)
  );

endmodule

// File: tb/tb_cluster_clock_gate_ctrl.sv
// Scoreboard bench: directed stimulus queues expected output values tagged
// with the clock edge they belong to; a negedge monitor pops and compares.
module tb_cluster_clock_gate_ctrl;

  typedef enum int {S_EN, S_ACK, S_RDY, S_CNT} sig_e;

  typedef struct {
    int          at;
    int          dut;
    sig_e        sig;
    logic [15:0] val;
    string       name;
  } exp_t;

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  logic sleep_req = 1'b0;
  logic busy = 1'b0;
  logic wake_req = 1'b0;
  logic test_mode = 1'b0;
  logic cnt_clr = 1'b0;

  logic        en_a, ack_a, rdy_a;
  logic [15:0] cnt_a;
  logic        en_b, ack_b, rdy_b;
  logic [3:0]  cnt_b;
  logic        en_c, ack_c, rdy_c;
  logic [15:0] cnt_c;

  int   edge_cnt = 0;
  int   base = 0;
  int   n_checks = 0;
  int   n_pass = 0;
  exp_t sb[$];
  exp_t mon_e;

  // a: default parameters; b: narrow counter; c: single-edge gate/ungate.
  cluster_clock_gate_ctrl #(.IDLE_CYCLES(8), .WAKE_CYCLES(2), .CNT_WIDTH(16)) u_dut_a (
    .clk_i(clk_i), .rst_i(rst_i), .sleep_req_i(sleep_req), .busy_i(busy),
    .wake_req_i(wake_req), .test_mode_i(test_mode), .cnt_clr_i(cnt_clr),
    .en_o(en_a), .sleep_ack_o(ack_a), .clk_ready_o(rdy_a), .gated_cnt_o(cnt_a));

  cluster_clock_gate_ctrl #(.IDLE_CYCLES(8), .WAKE_CYCLES(2), .CNT_WIDTH(4)) u_dut_b (
    .clk_i(clk_i), .rst_i(rst_i), .sleep_req_i(sleep_req), .busy_i(busy),
    .wake_req_i(wake_req), .test_mode_i(test_mode), .cnt_clr_i(cnt_clr),
    .en_o(en_b), .sleep_ack_o(ack_b), .clk_ready_o(rdy_b), .gated_cnt_o(cnt_b));

  cluster_clock_gate_ctrl #(.IDLE_CYCLES(1), .WAKE_CYCLES(0), .CNT_WIDTH(16)) u_dut_c (
    .clk_i(clk_i), .rst_i(rst_i), .sleep_req_i(sleep_req), .busy_i(busy),
    .wake_req_i(wake_req), .test_mode_i(test_mode), .cnt_clr_i(cnt_clr),
    .en_o(en_c), .sleep_ack_o(ack_c), .clk_ready_o(rdy_c), .gated_cnt_o(cnt_c));

  initial forever #5 clk_i = ~clk_i;

  always @(posedge clk_i) edge_cnt <= edge_cnt + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, edge %0d", edge_cnt);
    $fatal(1, "watchdog expired");
  end

  function automatic logic [15:0] actual(input int d, input sig_e s);
    logic [15:0] v;
    v = '0;
    case (d)
      0: case (s) S_EN: v = {15'd0, en_a}; S_ACK: v = {15'd0, ack_a};
                  S_RDY: v = {15'd0, rdy_a}; default: v = cnt_a; endcase
      1: case (s) S_EN: v = {15'd0, en_b}; S_ACK: v = {15'd0, ack_b};
                  S_RDY: v = {15'd0, rdy_b}; default: v = {12'd0, cnt_b}; endcase
      default: case (s) S_EN: v = {15'd0, en_c}; S_ACK: v = {15'd0, ack_c};
                  S_RDY: v = {15'd0, rdy_c}; default: v = cnt_c; endcase
    endcase
    return v;
  endfunction

  // Expectations are kept sorted by edge so the monitor only looks at the head.
  task automatic push_exp(input int rel, input int d, input sig_e s,
                          input logic [15:0] v, input string name);
    exp_t e;
    int   i;
    e.at = base + rel; e.dut = d; e.sig = s; e.val = v; e.name = name;
    i = 0;
    while (i < sb.size() && sb[i].at <= e.at) i++;
    sb.insert(i, e);
  endtask

  task automatic check(input exp_t e, input logic [15:0] act);
    n_checks++;
    if (e.at != edge_cnt)
      $display("FAIL %s dut%0d: expected at edge %0d, monitor reached it at edge %0d",
               e.name, e.dut, e.at, edge_cnt);
    else if (act !== e.val)
      $display("FAIL %s dut%0d edge %0d: got %0d, want %0d",
               e.name, e.dut, e.at, act, e.val);
    else
      n_pass++;
  endtask

  always @(negedge clk_i) begin
    while (sb.size() != 0 && sb[0].at <= edge_cnt) begin
      mon_e = sb.pop_front();
      check(mon_e, actual(mon_e.dut, mon_e.sig));
    end
  end

  task automatic wait_rel(input int r);
    while (edge_cnt < base + r) @(negedge clk_i);
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    rst_i = 1'b1; sleep_req = 1'b0; busy = 1'b0; wake_req = 1'b0;
    test_mode = 1'b0; cnt_clr = 1'b0;
    base = edge_cnt;
    for (int d = 0; d < 3; d++) begin
      push_exp(1, d, S_EN,  16'd1, "rst_en");
      push_exp(1, d, S_ACK, 16'd0, "rst_ack");
      push_exp(1, d, S_RDY, 16'd1, "rst_ready");
      push_exp(1, d, S_CNT, 16'd0, "rst_cnt");
    end
    @(negedge clk_i);
    rst_i = 1'b0;
    base = edge_cnt;
  endtask

  initial begin
    // Plan 1 + 2: default gating latency, count start, wake pulse and settle.
    do_reset();
    push_exp(7,  0, S_EN,  16'd1, "t1_en_before");
    push_exp(8,  0, S_EN,  16'd0, "t1_en_gated");
    push_exp(8,  0, S_ACK, 16'd1, "t1_ack");
    push_exp(8,  0, S_RDY, 16'd0, "t1_ready");
    push_exp(8,  0, S_CNT, 16'd0, "t1_cnt0");
    push_exp(9,  0, S_CNT, 16'd1, "t1_cnt1");
    push_exp(11, 0, S_CNT, 16'd3, "t1_cnt3");
    push_exp(1,  2, S_EN,  16'd0, "t1_c_single_gate");
    push_exp(1,  2, S_ACK, 16'd1, "t1_c_ack");
    push_exp(20, 0, S_EN,  16'd0, "t2_en_still_gated");
    push_exp(21, 0, S_EN,  16'd1, "t2_en_wake");
    push_exp(21, 0, S_ACK, 16'd0, "t2_ack_drop");
    push_exp(21, 0, S_RDY, 16'd0, "t2_ready_low");
    push_exp(21, 0, S_CNT, 16'd13, "t2_cnt_frozen");
    push_exp(22, 0, S_RDY, 16'd0, "t2_ready_settle");
    push_exp(22, 0, S_CNT, 16'd13, "t2_cnt_hold");
    push_exp(23, 0, S_RDY, 16'd1, "t2_ready_up");
    push_exp(21, 2, S_EN,  16'd1, "t2_c_single_ungate");
    push_exp(21, 2, S_RDY, 16'd1, "t2_c_ready");
    push_exp(21, 2, S_CNT, 16'd20, "t2_c_cnt");
    sleep_req = 1'b1;
    wait_rel(20); wake_req = 1'b1;
    wait_rel(21); wake_req = 1'b0;
    wait_rel(24);

    // Plan 3: busy pulse restarts the idle count.
    do_reset();
    push_exp(8,  0, S_EN,  16'd1, "t3_not_gated_at8");
    push_exp(13, 0, S_EN,  16'd1, "t3_en_before");
    push_exp(14, 0, S_EN,  16'd0, "t3_en_gated");
    push_exp(14, 0, S_ACK, 16'd1, "t3_ack");
    sleep_req = 1'b1;
    wait_rel(5); busy = 1'b1;
    wait_rel(6); busy = 1'b0;
    wait_rel(15);

    // Plan 4: 4-bit counter saturates; clear wins over increment.
    do_reset();
    push_exp(22, 1, S_CNT, 16'd14, "t4_cnt14");
    push_exp(23, 1, S_CNT, 16'd15, "t4_sat");
    push_exp(24, 1, S_CNT, 16'd15, "t4_sat_hold");
    push_exp(28, 1, S_CNT, 16'd15, "t4_sat_hold2");
    push_exp(28, 0, S_CNT, 16'd20, "t4_wide_no_sat");
    push_exp(29, 1, S_CNT, 16'd0, "t4_clr_wins");
    push_exp(29, 0, S_CNT, 16'd0, "t4_clr_wins_wide");
    push_exp(30, 1, S_CNT, 16'd1, "t4_count_resumes");
    sleep_req = 1'b1;
    wait_rel(28); cnt_clr = 1'b1;
    wait_rel(29); cnt_clr = 1'b0;
    wait_rel(31);

    // Plan 5: test mode holds the clock on; raising it while gated wakes.
    do_reset();
    for (int r = 5; r <= 30; r += 5) begin
      push_exp(r, 0, S_EN,  16'd1, "t5_en_forced");
      push_exp(r, 0, S_ACK, 16'd0, "t5_ack_low");
      push_exp(r, 2, S_EN,  16'd1, "t5_c_en_forced");
    end
    push_exp(37, 0, S_EN,  16'd1, "t5_drain");
    push_exp(38, 0, S_EN,  16'd0, "t5_gated");
    push_exp(35, 2, S_EN,  16'd0, "t5_c_gated");
    push_exp(41, 0, S_EN,  16'd1, "t5_tm_wake");
    push_exp(41, 0, S_RDY, 16'd0, "t5_tm_settle");
    push_exp(43, 0, S_RDY, 16'd1, "t5_tm_ready");
    push_exp(41, 2, S_EN,  16'd1, "t5_c_tm_wake");
    push_exp(41, 2, S_RDY, 16'd1, "t5_c_tm_ready");
    push_exp(50, 0, S_EN,  16'd1, "t5_stay_on");
    push_exp(50, 0, S_ACK, 16'd0, "t5_stay_noack");
    sleep_req = 1'b1; test_mode = 1'b1;
    wait_rel(30); test_mode = 1'b0;
    wait_rel(40); test_mode = 1'b1;
    wait_rel(51);

    // Plan 6: reset while gated, then sleep withdrawn while gated.
    do_reset();
    push_exp(12, 0, S_CNT, 16'd4, "t6_cnt_pre_rst");
    push_exp(12, 2, S_CNT, 16'd11, "t6_c_cnt_pre_rst");
    push_exp(13, 0, S_EN,  16'd1, "t6_rst_en");
    push_exp(13, 0, S_RDY, 16'd1, "t6_rst_ready");
    push_exp(13, 0, S_ACK, 16'd0, "t6_rst_ack");
    push_exp(13, 0, S_CNT, 16'd0, "t6_rst_cnt");
    push_exp(13, 2, S_EN,  16'd1, "t6_c_rst_en");
    push_exp(13, 2, S_CNT, 16'd0, "t6_c_rst_cnt");
    push_exp(14, 2, S_EN,  16'd0, "t6_c_regate");
    push_exp(20, 0, S_EN,  16'd1, "t6_redrain");
    push_exp(21, 0, S_EN,  16'd0, "t6_regate");
    push_exp(26, 0, S_EN,  16'd1, "t6_withdraw_en");
    push_exp(26, 0, S_ACK, 16'd0, "t6_withdraw_ack");
    push_exp(27, 0, S_RDY, 16'd0, "t6_withdraw_settle");
    push_exp(28, 0, S_RDY, 16'd1, "t6_withdraw_ready");
    push_exp(26, 2, S_EN,  16'd1, "t6_c_withdraw_en");
    push_exp(26, 2, S_RDY, 16'd1, "t6_c_withdraw_ready");
    push_exp(30, 0, S_ACK, 16'd0, "t6_idle_noack");
    sleep_req = 1'b1;
    wait_rel(12); rst_i = 1'b1;
    wait_rel(13); rst_i = 1'b0;
    wait_rel(25); sleep_req = 1'b0;
    wait_rel(31);

    repeat (3) @(negedge clk_i);
    while (sb.size() != 0) begin
      mon_e = sb.pop_front();
      n_checks++;
      $display("FAIL %s dut%0d: edge %0d never checked, got none, want %0d",
               mon_e.name, mon_e.dut, mon_e.at, mon_e.val);
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/cluster_clock_gate_ctrl.md
Name: cluster_clock_gate_ctrl

Overview:
Enable-side controller for the cluster clock gate cell. It runs on the free-running (ungated) cluster clock and decides when the cluster clock is switched off and on. Its en_o drives the gate cell's enable input. It implements a sleep request/acknowledge handshake with the cluster plus an idle-drain delay, a wake settle delay, and a saturating gated-cycle counter for power accounting.

Parameters:
IDLE_CYCLES, 8, consecutive qualified idle cycles required before gating (>=1)
WAKE_CYCLES, 2, cycles with enable high before clk_ready_o reasserts (>=0)
CNT_WIDTH, 16, width of the gated-cycle counter

Ports:
clk_i  input  1  free-running clock, never gated
rst_i  input  1  synchronous reset, active-high
sleep_req_i  input  1  cluster requests clock-off; level, held until sleep_ack_o or withdrawn
busy_i  input  1  cluster activity: core, DMA or bus transaction pending
wake_req_i  input  1  wake event (interrupt/event unit), level or pulse
test_mode_i  input  1  DFT mode: forces clock on
cnt_clr_i  input  1  clears gated_cnt_o
en_o  output  1  enable to clock gate cell
sleep_ack_o  output  1  high while clock is gated
clk_ready_o  output  1  gated clock is running and stable
gated_cnt_o  output  CNT_WIDTH  number of cycles spent gated, saturating

Behaviour:
- One clock, clk_i. Reset is synchronous and active-high (rst_i). All outputs are registered.
- Reset values: state ACTIVE, en_o=1, sleep_ack_o=0, clk_ready_o=1, gated_cnt_o=0, internal counters 0.
- Qualifier q = sleep_req_i & ~busy_i & ~wake_req_i & ~test_mode_i.
- Wake condition w = wake_req_i | busy_i | ~sleep_req_i | test_mode_i.
- States:
  - ACTIVE: en=1, ack=0, ready=1.
    - If q and IDLE_CYCLES==1, go to GATED.
    - Else if q, go to DRAIN with idle_cnt=1.
  - DRAIN: en=1, ack=0, ready=1.
    - If ~q, go to ACTIVE and idle_cnt=0.
    - Else if idle_cnt==IDLE_CYCLES-1, go to GATED.
    - Else idle_cnt++.
  - GATED: en=0, ack=1, ready=0.
    - gated_cnt increments by 1 each cycle in GATED and saturates at all-ones.
    - If w, go to WAKE (or to ACTIVE when WAKE_CYCLES==0) with wake_cnt=0.
  - WAKE: en=1, ack=0, ready=0.
    - wake_cnt++ each cycle. When wake_cnt==WAKE_CYCLES-1, go to ACTIVE.
    - sleep_req_i is ignored in WAKE.
- Latency: en_o falls on the clock edge that ends the IDLE_CYCLES-th consecutive q cycle. en_o rises on the edge after the first w cycle in GATED. clk_ready_o rises WAKE_CYCLES edges after en_o rises.
- test_mode_i=1 in any state: the next state is ACTIVE (via WAKE if currently GATED, honouring WAKE_CYCLES), and idle_cnt is cleared. en_o is never low while test_mode_i=1, except during the single cycle of the GATED->WAKE transition edge.
- Simultaneous events:
  - wake_req_i together with sleep_req_i: wake wins.
  - cnt_clr_i together with an increment: clear wins, result 0.
  - q dropping on the same cycle idle_cnt would reach its limit: no gating.
- rst_i mid-operation (e.g. in GATED) returns to ACTIVE with en_o=1 on the next edge. gated_cnt_o is cleared.
- sleep_req_i withdrawn before ack: the controller aborts to ACTIVE (DRAIN) or wakes (GATED). sleep_ack_o never pulses without en_o=0.

Decomposition:
- Shared package cluster_pm_pkg: state enum (ACTIVE, DRAIN, GATED, WAKE), default constants for IDLE_CYCLES and WAKE_CYCLES.
- One natural sub-module: cluster_sat_counter (parameterised width, inc, clr, clear priority). Used for gated_cnt. Idle/wake counters stay inline.
- The gate cell itself is instantiated by the parent, not inside this block.

Test Plan:
1. Defaults. sleep_req_i=1, busy_i=0 from cycle 0. Required: en_o=0 and sleep_ack_o=1 after edge 8. gated_cnt_o counts 1,2,3,... from edge 9.
2. Gated, then a 1-cycle wake_req_i pulse at cycle 20. Required: en_o=1 at edge 21, sleep_ack_o=0 at edge 21, clk_ready_o=1 at edge 23.
3. sleep_req_i=1 with busy_i pulsed high at cycle 5. Required: idle count restarts; en_o falls at edge 14, not 8.
4. CNT_WIDTH=4, held gated for 20 cycles. Required: gated_cnt_o saturates at 15. Then cnt_clr_i together with an increment gives gated_cnt_o=0.
5. test_mode_i=1 throughout with sleep_req_i=1. Required: en_o stays 1 and sleep_ack_o stays 0 indefinitely.
6. rst_i asserted for 1 cycle while GATED. Required: next edge gives en_o=1, clk_ready_o=1, gated_cnt_o=0, state ACTIVE. Also run IDLE_CYCLES=1 / WAKE_CYCLES=0 variants to confirm single-edge gate and ungate.
